// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of one single-port memory.
// After reset the whole memory is swept to zero (INIT -> CLEAR -> RUN).
// Only then are requester accesses granted, one per cycle.
//
// Handshake: a requester raises I_reqN and holds it, together with
// I_wenN/I_addrN/I_wdataN, until it sees O_gntN high in the same cycle.
// Each cycle with O_gntN high performs exactly one access. A granted read
// returns its data one cycle later as a single-cycle O_rvalidN pulse,
// with the data on O_rdataN. There is no backpressure on the read return.
module mem_arbiter #(
  parameter int C_WORDSIZE = 8,
  parameter int C_ADDRSIZE = 10
) (
  input  logic                  I_clk,
  input  logic                  I_rst_n,
  input  logic                  I_clr,
  output logic                  O_ready,
  // requester 0
  input  logic                  I_req0,
  input  logic                  I_wen0,
  input  logic [C_ADDRSIZE-1:0] I_addr0,
  input  logic [C_WORDSIZE-1:0] I_wdata0,
  output logic                  O_gnt0,
  output logic                  O_rvalid0,
  output logic [C_WORDSIZE-1:0] O_rdata0,
  // requester 1
  input  logic                  I_req1,
  input  logic                  I_wen1,
  input  logic [C_ADDRSIZE-1:0] I_addr1,
  input  logic [C_WORDSIZE-1:0] I_wdata1,
  output logic                  O_gnt1,
  output logic                  O_rvalid1,
  output logic [C_WORDSIZE-1:0] O_rdata1,
  // memory side
  output logic                  O_mem_wen,
  output logic [C_ADDRSIZE-1:0] O_mem_addr,
  output logic [C_WORDSIZE-1:0] O_mem_wdata,
  input  logic [C_WORDSIZE-1:0] I_mem_rdata,
  // debug: current FSM state (0 = INIT, 1 = CLEAR, 2 = RUN)
  output logic [1:0]            O_state
);

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  localparam logic [C_ADDRSIZE-1:0] CLR_LAST = '1;
  localparam logic [C_ADDRSIZE-1:0] CLR_STEP = {{(C_ADDRSIZE-1){1'b0}}, 1'b1};

  state_t                  state;
  logic [C_ADDRSIZE-1:0]   clr_cnt;
  logic                    last_gnt1;   // 1: port 1 was granted most recently
  logic [C_ADDRSIZE-1:0]   hold_addr;
  logic [C_WORDSIZE-1:0]   hold_wdata;
  logic                    gnt0;
  logic                    gnt1;
  logic                    mem_wen;
  logic [C_ADDRSIZE-1:0]   mem_addr;
  logic [C_WORDSIZE-1:0]   mem_wdata;

  // Round-robin grant. A clear request in RUN suppresses grants so that no
  // access slips in ahead of the sweep that is about to start.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state == ST_RUN && !I_clr) begin
      if (I_req0 && I_req1) begin
        gnt0 = last_gnt1;
        gnt1 = !last_gnt1;
      end else begin
        gnt0 = I_req0;
        gnt1 = I_req1;
      end
    end
  end

  // Memory port mux: the clear sweep, else the granted requester, else idle.
  // When idle, the last address and data are held.
  always_comb begin
    mem_wen   = 1'b0;
    mem_addr  = hold_addr;
    mem_wdata = hold_wdata;
    if (state == ST_CLEAR) begin
      mem_wen   = 1'b1;
      mem_addr  = clr_cnt;
      mem_wdata = '0;
    end else if (gnt0) begin
      mem_wen   = I_wen0;
      mem_addr  = I_addr0;
      mem_wdata = I_wdata0;
    end else if (gnt1) begin
      mem_wen   = I_wen1;
      mem_addr  = I_addr1;
      mem_wdata = I_wdata1;
    end
  end

  // Main FSM and clear counter. A clear request restarts the sweep from 0.
  always_ff @(posedge I_clk) begin
    if (!I_rst_n) begin
      state   <= ST_INIT;
      clr_cnt <= '0;
    end else begin
      case (state)
        ST_INIT: begin
          state   <= ST_CLEAR;
          clr_cnt <= '0;
        end
        ST_CLEAR: begin
          if (I_clr) begin
            clr_cnt <= '0;
          end else if (clr_cnt == CLR_LAST) begin
            state   <= ST_RUN;
            clr_cnt <= '0;
          end else begin
            clr_cnt <= clr_cnt + CLR_STEP;
          end
        end
        ST_RUN: begin
          if (I_clr) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
          end
        end
        default: begin
          state   <= ST_INIT;
          clr_cnt <= '0;
        end
      endcase
    end
  end

  // Round-robin history; port 0 wins the first contention after reset.
  always_ff @(posedge I_clk) begin
    if (!I_rst_n) begin
      last_gnt1 <= 1'b1;
    end else if (gnt0) begin
      last_gnt1 <= 1'b0;
    end else if (gnt1) begin
      last_gnt1 <= 1'b1;
    end
  end

  // Remember the last driven address and data so the bus is quiet when idle.
  always_ff @(posedge I_clk) begin
    if (!I_rst_n) begin
      hold_addr  <= '0;
      hold_wdata <= '0;
    end else if (mem_wen || gnt0 || gnt1) begin
      hold_addr  <= mem_addr;
      hold_wdata <= mem_wdata;
    end
  end

  // Read return path: capture memory data on a read grant and pulse valid.
  always_ff @(posedge I_clk) begin
    if (!I_rst_n) begin
      O_rvalid0 <= 1'b0;
      O_rvalid1 <= 1'b0;
      O_rdata0  <= '0;
      O_rdata1  <= '0;
    end else begin
      O_rvalid0 <= gnt0 && !I_wen0;
      O_rvalid1 <= gnt1 && !I_wen1;
      if (gnt0 && !I_wen0) begin
        O_rdata0 <= I_mem_rdata;
      end
      if (gnt1 && !I_wen1) begin
        O_rdata1 <= I_mem_rdata;
      end
    end
  end

  assign O_gnt0      = gnt0;
  assign O_gnt1      = gnt1;
  assign O_mem_wen   = mem_wen;
  assign O_mem_addr  = mem_addr;
  assign O_mem_wdata = mem_wdata;
  assign O_ready     = (state == ST_RUN);
  assign O_state     = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter with a 16-word memory model. It runs the reset and
// clear sweep, then a table of single-cycle arbitration vectors. It ends with
// hand-written sequences for a clear request and for reset during a read.
module tb_mem_arbiter;

  localparam int W = 8;
  localparam int A = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, clr, ready;
  logic         req0, wen0, gnt0, rvalid0;
  logic [A-1:0] addr0;
  logic [W-1:0] wdata0, rdata0;
  logic         req1, wen1, gnt1, rvalid1;
  logic [A-1:0] addr1;
  logic [W-1:0] wdata1, rdata1;
  logic         mem_wen;
  logic [A-1:0] mem_addr;
  logic [W-1:0] mem_wdata, mem_rdata;
  logic [1:0]   state;

  mem_arbiter #(.C_WORDSIZE(W), .C_ADDRSIZE(A)) dut (
    .I_clk(clk), .I_rst_n(rst_n), .I_clr(clr), .O_ready(ready),
    .I_req0(req0), .I_wen0(wen0), .I_addr0(addr0), .I_wdata0(wdata0),
    .O_gnt0(gnt0), .O_rvalid0(rvalid0), .O_rdata0(rdata0),
    .I_req1(req1), .I_wen1(wen1), .I_addr1(addr1), .I_wdata1(wdata1),
    .O_gnt1(gnt1), .O_rvalid1(rvalid1), .O_rdata1(rdata1),
    .O_mem_wen(mem_wen), .O_mem_addr(mem_addr), .O_mem_wdata(mem_wdata),
    .I_mem_rdata(mem_rdata), .O_state(state)
  );

  // single-port memory model, combinational read
  logic [W-1:0] mem [16];
  always @(posedge clk) if (mem_wen) mem[mem_addr] <= mem_wdata;
  assign mem_rdata = mem[mem_addr];

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];
  logic [W-1:0] last_rd0, last_rd1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive0(input logic r, input logic w, input logic [A-1:0] a, input logic [W-1:0] d);
    req0 = r; wen0 = w; addr0 = a; wdata0 = d;
  endtask

  task automatic drive1(input logic r, input logic w, input logic [A-1:0] a, input logic [W-1:0] d);
    req1 = r; wen1 = w; addr1 = a; wdata1 = d;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic req0; logic wen0; logic [A-1:0] addr0; logic [W-1:0] wdata0;
    logic req1; logic wen1; logic [A-1:0] addr1; logic [W-1:0] wdata1;
    logic gnt0; logic gnt1; logic mwen; logic [A-1:0] maddr; logic [W-1:0] mwdata;
    logic [W-1:0] rd;
  } vec_t;

  vec_t vecs [16];

  initial begin
    // inputs                                               | expected: gnt0 gnt1 wen addr wdata readdata
    vecs[0]  = '{1'b1,1'b1,4'h3,8'h5A, 1'b0,1'b0,4'h0,8'h00, 1'b1,1'b0,1'b1,4'h3,8'h5A,8'h00};
    vecs[1]  = '{1'b1,1'b0,4'h3,8'h00, 1'b0,1'b0,4'h0,8'h00, 1'b1,1'b0,1'b0,4'h3,8'h00,8'h5A};
    vecs[2]  = '{1'b0,1'b0,4'h0,8'h00, 1'b0,1'b0,4'h0,8'h00, 1'b0,1'b0,1'b0,4'h3,8'h00,8'h00};
    vecs[3]  = '{1'b0,1'b0,4'h0,8'h00, 1'b1,1'b1,4'h7,8'hFF, 1'b0,1'b1,1'b1,4'h7,8'hFF,8'h00};
    vecs[4]  = '{1'b1,1'b0,4'h3,8'h00, 1'b1,1'b0,4'h7,8'h00, 1'b1,1'b0,1'b0,4'h3,8'h00,8'h5A};
    vecs[5]  = '{1'b1,1'b0,4'h3,8'h00, 1'b1,1'b0,4'h7,8'h00, 1'b0,1'b1,1'b0,4'h7,8'h00,8'hFF};
    vecs[6]  = '{1'b1,1'b0,4'h3,8'h00, 1'b1,1'b0,4'h7,8'h00, 1'b1,1'b0,1'b0,4'h3,8'h00,8'h5A};
    vecs[7]  = '{1'b1,1'b0,4'h3,8'h00, 1'b1,1'b0,4'h7,8'h00, 1'b0,1'b1,1'b0,4'h7,8'h00,8'hFF};
    vecs[8]  = '{1'b0,1'b0,4'h0,8'h00, 1'b1,1'b0,4'h3,8'h00, 1'b0,1'b1,1'b0,4'h3,8'h00,8'h5A};
    vecs[9]  = '{1'b0,1'b0,4'h0,8'h00, 1'b1,1'b0,4'h3,8'h00, 1'b0,1'b1,1'b0,4'h3,8'h00,8'h5A};
    vecs[10] = '{1'b1,1'b1,4'h3,8'h11, 1'b1,1'b1,4'h5,8'h22, 1'b1,1'b0,1'b1,4'h3,8'h11,8'h00};
    vecs[11] = '{1'b0,1'b0,4'h0,8'h00, 1'b1,1'b1,4'h5,8'h22, 1'b0,1'b1,1'b1,4'h5,8'h22,8'h00};
    vecs[12] = '{1'b0,1'b0,4'h0,8'h00, 1'b1,1'b0,4'h5,8'h22, 1'b0,1'b1,1'b0,4'h5,8'h22,8'h22};
    vecs[13] = '{1'b0,1'b0,4'h0,8'h00, 1'b0,1'b0,4'h0,8'h00, 1'b0,1'b0,1'b0,4'h5,8'h22,8'h00};
    vecs[14] = '{1'b1,1'b0,4'h3,8'h00, 1'b0,1'b0,4'h0,8'h00, 1'b1,1'b0,1'b0,4'h3,8'h00,8'h11};
    vecs[15] = '{1'b0,1'b0,4'h0,8'h00, 1'b0,1'b0,4'h0,8'h00, 1'b0,1'b0,1'b0,4'h3,8'h00,8'h00};
  end

  // ---------------- test sequence ----------------
  initial begin
    rst_n = 1'b0; clr = 1'b0;
    drive0(1'b0, 1'b0, '0, '0);
    drive1(1'b0, 1'b0, '0, '0);
    last_rd0 = '0; last_rd1 = '0;

    // reset values
    repeat (3) @(posedge clk);
    @(negedge clk); #2;
    check("rst_ready", ready, 0);
    check("rst_state", state, 0);
    check("rst_gnt0", gnt0, 0);
    check("rst_gnt1", gnt1, 0);
    check("rst_rvalid0", rvalid0, 0);
    check("rst_rvalid1", rvalid1, 0);
    check("rst_rdata0", rdata0, 0);
    check("rst_rdata1", rdata1, 0);
    check("rst_mem_wen", mem_wen, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);

    // release: one quiet cycle, 16 clear writes, then RUN. Port 0 holds a
    // read of addr 0 throughout and must only be granted once RUN is reached.
    @(negedge clk);
    rst_n = 1'b1;
    drive0(1'b1, 1'b0, 4'h0, 8'h00);
    #2;
    check("init_quiet_wen", mem_wen, 0);
    check("init_no_gnt", gnt0, 0);
    check("init_ready", ready, 0);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk); #2;
      check("clr_wen", mem_wen, 1);
      check("clr_addr", mem_addr, i);
      check("clr_wdata", mem_wdata, 0);
      check("clr_no_gnt", gnt0, 0);
      check("clr_ready", ready, 0);
    end
    @(negedge clk); #2;
    check("run_ready", ready, 1);
    check("run_state", state, 2);
    check("run_first_gnt0", gnt0, 1);
    check("run_first_addr", mem_addr, 0);
    @(posedge clk); #1;
    check("run_first_rvalid0", rvalid0, 1);
    check("run_first_rdata0", rdata0, 8'h00);
    last_rd0 = 8'h00;

    // table-driven single-cycle arbitration vectors
    for (int v = 0; v < 16; v++) begin
      @(negedge clk);
      drive0(vecs[v].req0, vecs[v].wen0, vecs[v].addr0, vecs[v].wdata0);
      drive1(vecs[v].req1, vecs[v].wen1, vecs[v].addr1, vecs[v].wdata1);
      #2;
      check($sformatf("v%0d_gnt0", v), gnt0, vecs[v].gnt0);
      check($sformatf("v%0d_gnt1", v), gnt1, vecs[v].gnt1);
      check($sformatf("v%0d_mem_wen", v), mem_wen, vecs[v].mwen);
      check($sformatf("v%0d_mem_addr", v), mem_addr, vecs[v].maddr);
      check($sformatf("v%0d_mem_wdata", v), mem_wdata, vecs[v].mwdata);
      if (vecs[v].gnt0 && !vecs[v].wen0) exp_q0.push_back(vecs[v].rd);
      if (vecs[v].gnt1 && !vecs[v].wen1) exp_q1.push_back(vecs[v].rd);
      @(posedge clk); #1;
      check($sformatf("v%0d_rvalid0", v), rvalid0, vecs[v].gnt0 && !vecs[v].wen0);
      check($sformatf("v%0d_rvalid1", v), rvalid1, vecs[v].gnt1 && !vecs[v].wen1);
      if (exp_q0.size() > 0) last_rd0 = exp_q0.pop_front();
      if (exp_q1.size() > 0) last_rd1 = exp_q1.pop_front();
      check($sformatf("v%0d_rdata0", v), rdata0, last_rd0);
      check($sformatf("v%0d_rdata1", v), rdata1, last_rd1);
    end

    // clear request while port 1 waits to read addr 7 (just written 0xFF).
    // A second clear pulse during the sweep at addr 5 restarts it from 0.
    @(negedge clk);
    drive0(1'b1, 1'b1, 4'h7, 8'hFF);
    drive1(1'b0, 1'b0, '0, '0);
    #2;
    check("clr_seq_wr_gnt0", gnt0, 1);
    @(negedge clk);
    drive0(1'b0, 1'b0, '0, '0);
    drive1(1'b1, 1'b0, 4'h7, 8'h00);
    clr = 1'b1;
    #2;
    check("clr_pulse_no_gnt1", gnt1, 0);
    check("clr_pulse_wen", mem_wen, 0);
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      clr = (i == 5);
      #2;
      check("clr2_wen", mem_wen, 1);
      check("clr2_addr", mem_addr, (i <= 5) ? i : i - 6);
      check("clr2_no_gnt1", gnt1, 0);
      check("clr2_ready", ready, 0);
    end
    @(negedge clk);
    clr = 1'b0;
    #2;
    check("clr2_ready_after", ready, 1);
    check("clr2_gnt1", gnt1, 1);
    check("clr2_addr7", mem_addr, 7);
    @(posedge clk); #1;
    check("clr2_rvalid1", rvalid1, 1);
    check("clr2_rdata1", rdata1, 8'h00);

    // reset sampled at the edge that ends a read grant: no valid pulse,
    // everything returns to reset values, and the sweep restarts.
    @(negedge clk);
    drive1(1'b0, 1'b0, '0, '0);
    drive0(1'b1, 1'b0, 4'h3, 8'h00);
    rst_n = 1'b0;
    #2;
    check("rst2_gnt0_before", gnt0, 1);
    @(posedge clk); #1;
    check("rst2_rvalid0", rvalid0, 0);
    check("rst2_rdata0", rdata0, 0);
    check("rst2_rdata1", rdata1, 0);
    check("rst2_ready", ready, 0);
    check("rst2_gnt0", gnt0, 0);
    check("rst2_state", state, 0);
    check("rst2_mem_wen", mem_wen, 0);
    check("rst2_mem_addr", mem_addr, 0);
    check("rst2_mem_wdata", mem_wdata, 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive0(1'b0, 1'b0, '0, '0);
    #2;
    check("rst2_quiet", mem_wen, 0);
    check("rst2_rvalid0_quiet", rvalid0, 0);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk); #2;
      check("rst2_clr_wen", mem_wen, 1);
      check("rst2_clr_addr", mem_addr, i);
    end

    // both ports hold reads: grants alternate starting with port 0
    @(negedge clk);
    drive0(1'b1, 1'b0, 4'h3, 8'h00);
    drive1(1'b1, 1'b0, 4'h7, 8'h00);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      #2;
      check("alt_ready", ready, 1);
      check($sformatf("alt%0d_gnt0", k), gnt0, (k % 2) == 0);
      check($sformatf("alt%0d_gnt1", k), gnt1, (k % 2) == 1);
    end
    @(negedge clk);
    drive0(1'b0, 1'b0, '0, '0);
    drive1(1'b0, 1'b0, '0, '0);
    repeat (2) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001: The module SHALL have parameter C_WORDSIZE, default 8, memory data width in bits.
REQ-002: The module SHALL have parameter C_ADDRSIZE, default 10, memory address width; memory depth is 2^C_ADDRSIZE.
REQ-003: The module SHALL have port I_clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004: The module SHALL have port I_rst_n, input, 1; reset is synchronous and active-low.
REQ-005: The module SHALL have port I_clr, input, 1, single-cycle request to restart the memory-clear sweep.
REQ-006: The module SHALL have port O_ready, output, 1, high when in RUN (clear complete).
REQ-007: The module SHALL have ports I_reqN, input, 1 (N=0,1), access request from requester N.
REQ-008: The module SHALL have ports I_wenN, input, 1, access type: 1 = write, 0 = read.
REQ-009: The module SHALL have ports I_addrN, input, C_ADDRSIZE, access address.
REQ-010: The module SHALL have ports I_wdataN, input, C_WORDSIZE, write data.
REQ-011: The module SHALL have ports O_gntN, output, 1, access accepted this cycle.
REQ-012: The module SHALL have ports O_rvalidN, output, 1, read data valid.
REQ-013: The module SHALL have ports O_rdataN, output, C_WORDSIZE, read data.
REQ-014: The module SHALL have port O_mem_wen, output, 1, write enable to the single-port memory.
REQ-015: The module SHALL have port O_mem_addr, output, C_ADDRSIZE, memory address.
REQ-016: The module SHALL have port O_mem_wdata, output, C_WORDSIZE, memory write data.
REQ-017: The module SHALL have port I_mem_rdata, input, C_WORDSIZE, memory read data, combinational from O_mem_addr.

Function
REQ-018: The FSM SHALL have three states: INIT, CLEAR, RUN.
REQ-019: INIT SHALL last one cycle after reset release with no memory activity, then go to CLEAR.
REQ-020: CLEAR SHALL assert O_mem_wen with O_mem_wdata=0 and O_mem_addr = a clear counter stepping 0..2^C_ADDRSIZE-1, one address per cycle.
REQ-021: CLEAR SHALL go to RUN on the cycle after address 2^C_ADDRSIZE-1 is written; O_ready=1 only in RUN.
REQ-022: I_clr in RUN SHALL move the FSM to CLEAR on the next cycle with the counter at 0; I_clr in CLEAR SHALL restart the counter at 0; I_clr in INIT SHALL be ignored.
REQ-023: O_gnt0/O_gnt1 SHALL be 0 outside RUN; requesters hold I_reqN and request fields until granted, so no request is lost.
REQ-024: In RUN, a grant SHALL be combinational in the same cycle as I_reqN, at most one grant per cycle, one access per grant.
REQ-025: Arbitration SHALL be round-robin: a single requester is always granted; with both requesting, the port not granted last wins; after reset port 0 has priority.
REQ-026: During a grant, O_mem_wen/addr/wdata SHALL be driven from the granted port; with no grant, O_mem_wen=0 and addr/wdata hold their last values.
REQ-027: On a read grant, I_mem_rdata SHALL be registered; O_rvalidN pulses for exactly one cycle on the next cycle with O_rdataN (1-cycle latency).
REQ-028: Writes SHALL produce no O_rvalidN; O_rdataN SHALL hold its value between reads.
REQ-029: Back-to-back requests SHALL be supported: a held I_reqN is granted every cycle when it is the only requester.

Reset
REQ-030: While I_rst_n=0 at a clock edge, state SHALL be INIT, clear counter 0, priority to port 0, and O_gntN=0, O_rvalidN=0, O_rdataN=0, O_ready=0, O_mem_wen=0, O_mem_addr=0, O_mem_wdata=0.
REQ-031: Reset mid-operation SHALL drop any in-flight O_rvalidN and restart the INIT/CLEAR sequence.

Verification
REQ-032: C_ADDRSIZE=4, release reset -> one quiet cycle, then O_mem_wen=1 for 16 cycles with addr 0..15 and data 0; O_ready rises on the 18th cycle after release; no grants.
REQ-033: Port 0 writes 0x5A to addr 3, then reads addr 3 -> O_gnt0 one cycle each; O_rvalid0=1 with O_rdata0=0x5A exactly one cycle after the read grant.
REQ-034: Both ports hold continuous read requests after O_ready -> grants alternate 0,1,0,1, starting with port 0, one per cycle.
REQ-035: Write 0xFF to addr 7, pulse I_clr while I_req1 reads addr 7 -> no grant for 16 clear cycles, then O_gnt1 is given and O_rdata1=0x00.
REQ-036: Assert I_rst_n=0 on the cycle after a read grant -> O_rvalidN stays 0, all outputs take REQ-030 values, and the clear sweep restarts after release.
